// File: rtl/nndz_sampler_pkg.sv
// Shared types and helpers for the nndz four-state observation stage.
// Combinational helpers only; no state.
// No flow control of its own.
package nndz_sampler_pkg;

    typedef enum logic [1:0] {
        C0 = 2'b00,
        C1 = 2'b01,
        CX = 2'b10,
        CZ = 2'b11
    } code_t;

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    localparam int NUM_BITS = 13;
    localparam int IDX_W    = 4;

    // Case equality keeps X and Z distinguishable from each other and from 0/1.
    function automatic code_t classify(input logic b);
        code_t c;
        if (b === 1'b0)      c = C0;
        else if (b === 1'b1) c = C1;
        else if (b === 1'bx) c = CX;
        else                 c = CZ;
        return c;
    endfunction

endpackage

// File: rtl/nndz_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats a coincident increment.
// Latency: q reflects inc/clr one edge later.
// No backpressure; inc is taken every cycle it is high.
module nndz_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/nndz_sampler.sv
// Snapshots nndz four-state outputs and streams a 0/1/X/Z code per bit with saturating X/Z totals.
// Latency: first beat valid the cycle after start is sampled; 13 beats per snapshot, one per accepted cycle.
// Backpressure: current beat (code/idx/last) holds while out_ready is low; totals only move on accepted beats.
module nndz_sampler
    import nndz_sampler_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clr_stats,
    input  logic             gikybab [3:4][1:3],
    input  logic [3:1][0:1]  ewgtcyo,
    input  logic             wozozd,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_code,
    output logic [3:0]       out_idx,
    output logic             out_last,
    output logic             snap_unknown,
    output logic [CNT_W-1:0] x_total,
    output logic [CNT_W-1:0] z_total
);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q;
    logic [NUM_BITS-1:0] snap_q;
    logic [NUM_BITS-1:0] flat;
    logic                flat_unknown;
    logic                capture;
    logic                xfer;
    logic                at_last;
    code_t               code_cur;

    always_comb begin
        flat     = '0;
        flat[0]  = gikybab[3][1];
        flat[1]  = gikybab[3][2];
        flat[2]  = gikybab[3][3];
        flat[3]  = gikybab[4][1];
        flat[4]  = gikybab[4][2];
        flat[5]  = gikybab[4][3];
        flat[6]  = ewgtcyo[3][0];
        flat[7]  = ewgtcyo[3][1];
        flat[8]  = ewgtcyo[2][0];
        flat[9]  = ewgtcyo[2][1];
        flat[10] = ewgtcyo[1][0];
        flat[11] = ewgtcyo[1][1];
        flat[12] = wozozd;
    end

    always_comb begin
        flat_unknown = 1'b0;
        for (int i = 0; i < NUM_BITS; i++) begin
            if (classify(flat[i]) inside {CX, CZ}) flat_unknown = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        code_cur  = C0;
        at_last   = (idx_q == IDX_W'(NUM_BITS - 1));
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_SEND;
            end
            S_SEND: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_last  = at_last;
                code_cur  = classify(snap_q[idx_q]);
                if (out_ready && at_last) state_d = S_IDLE;
            end
        endcase
        capture  = (state_q == S_IDLE) && start;
        xfer     = out_valid && out_ready;
        out_code = code_cur;
        out_idx  = idx_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            snap_q       <= '0;
            snap_unknown <= 1'b0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                snap_q       <= flat;
                snap_unknown <= flat_unknown;
                idx_q        <= '0;
            end else if (xfer) begin
                idx_q <= at_last ? '0 : idx_q + IDX_W'(1);
            end
        end
    end

    nndz_sat_counter #(.W(CNT_W)) u_x_cnt (
        .clk (clk),
        .rst (rst),
        .inc (xfer && (code_cur == CX)),
        .clr (clr_stats),
        .q   (x_total)
    );

    nndz_sat_counter #(.W(CNT_W)) u_z_cnt (
        .clk (clk),
        .rst (rst),
        .inc (xfer && (code_cur == CZ)),
        .clr (clr_stats),
        .q   (z_total)
    );

endmodule

// File: tb/tb_nndz_sampler.sv
// Directed bench for nndz_sampler: 8-bit and 4-bit counter instances share one stimulus.
module tb_nndz_sampler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, start, clr_stats, out_ready;
    logic            gikybab [3:4][1:3];
    logic [3:1][0:1] ewgtcyo;
    logic            wozozd;

    logic       busy, out_valid, out_last, snap_unknown;
    logic [1:0] out_code;
    logic [3:0] out_idx;
    logic [7:0] x_total, z_total;

    logic       busy4, out_valid4, out_last4, snap_unknown4;
    logic [1:0] out_code4;
    logic [3:0] out_idx4;
    logic [3:0] x4, z4;

    int checks = 0;
    int passes = 0;

    logic       is4;
    logic [1:0] exp_known [13];
    logic [1:0] exp_pow   [13];
    int kx, kz, px, pz, px_tail, pz_tail;
    int e8x, e8z;

    nndz_sampler #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .clr_stats(clr_stats),
        .gikybab(gikybab), .ewgtcyo(ewgtcyo), .wozozd(wozozd),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_code(out_code), .out_idx(out_idx), .out_last(out_last),
        .snap_unknown(snap_unknown), .x_total(x_total), .z_total(z_total)
    );

    nndz_sampler #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .clr_stats(clr_stats),
        .gikybab(gikybab), .ewgtcyo(ewgtcyo), .wozozd(wozozd),
        .busy(busy4), .out_valid(out_valid4), .out_ready(out_ready),
        .out_code(out_code4), .out_idx(out_idx4), .out_last(out_last4),
        .snap_unknown(snap_unknown4), .x_total(x4), .z_total(z4)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // g = {g[3][1],g[3][2],g[3][3],g[4][1],g[4][2],g[4][3]}
    task automatic set_inputs(input logic [5:0] g, input logic [5:0] e, input logic w);
        gikybab[3][1] = g[5];
        gikybab[3][2] = g[4];
        gikybab[3][3] = g[3];
        gikybab[4][1] = g[2];
        gikybab[4][2] = g[1];
        gikybab[4][3] = g[0];
        ewgtcyo       = e;
        wozozd        = w;
    endtask

    function automatic logic tb_flat(input int i);
        case (i)
            0:  return gikybab[3][1];
            1:  return gikybab[3][2];
            2:  return gikybab[3][3];
            3:  return gikybab[4][1];
            4:  return gikybab[4][2];
            5:  return gikybab[4][3];
            6:  return ewgtcyo[3][0];
            7:  return ewgtcyo[3][1];
            8:  return ewgtcyo[2][0];
            9:  return ewgtcyo[2][1];
            10: return ewgtcyo[1][0];
            11: return ewgtcyo[1][1];
            default: return wozozd;
        endcase
    endfunction

    function automatic logic [1:0] model_code(input logic b);
        if (b === 1'b1)      return 2'b01;
        else if (b === 1'b0) return 2'b00;
        else if (b === 1'bz) return 2'b11;
        else                 return 2'b10;
    endfunction

    function automatic int sat4(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    // Hand tables hold; a two-state simulator folds X/Z on the inputs, so it falls back to the model.
    task automatic build_tables;
        logic       probe;
        logic [1:0] hk [13];
        logic [1:0] hp [13];
        hk = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00,
               2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
        hp = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b11, 2'b10,
               2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
        probe = 1'bx;
        is4 = (probe !== 1'b0) && (probe !== 1'b1);
        set_inputs(6'b101010, 6'b000000, 1'b1);
        for (int i = 0; i < 13; i++) exp_known[i] = is4 ? hk[i] : model_code(tb_flat(i));
        set_inputs(6'bx010xz, 6'bxxxxxx, 1'bx);
        for (int i = 0; i < 13; i++) exp_pow[i] = is4 ? hp[i] : model_code(tb_flat(i));
        kx = 0; kz = 0; px = 0; pz = 0; px_tail = 0; pz_tail = 0;
        for (int i = 0; i < 13; i++) begin
            if (exp_known[i] == 2'b10) kx++;
            if (exp_known[i] == 2'b11) kz++;
            if (exp_pow[i] == 2'b10) begin px++; if (i > 0) px_tail++; end
            if (exp_pow[i] == 2'b11) begin pz++; if (i > 0) pz_tail++; end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; clr_stats = 1'b0; out_ready = 1'b0;
        set_inputs(6'b101010, 6'b000000, 1'b1);
        tick; tick;
        checks++; if ({busy, out_valid, out_last} !== 3'b000) $display("FAIL reset_ctl got %b want 000", {busy, out_valid, out_last}); else passes++;
        checks++; if (out_code !== 2'b00) $display("FAIL reset_code got %b want 00", out_code); else passes++;
        checks++; if (out_idx !== 4'd0) $display("FAIL reset_idx got %0d want 0", out_idx); else passes++;
        checks++; if ({x_total, z_total} !== 16'd0) $display("FAIL reset_totals got %0d/%0d want 0/0", x_total, z_total); else passes++;
        checks++; if (snap_unknown !== 1'b0) $display("FAIL reset_unknown got %b want 0", snap_unknown); else passes++;
        checks++; if ({x4, z4} !== 8'd0) $display("FAIL reset_totals4 got %0d/%0d want 0/0", x4, z4); else passes++;
        rst = 1'b0;
        tick;
        checks++; if (busy !== 1'b0) $display("FAIL idle_no_start busy got %b want 0", busy); else passes++;
        e8x = 0; e8z = 0;
    endtask

    task automatic test_known;
        set_inputs(6'b101010, 6'b000000, 1'b1);
        out_ready = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        set_inputs(6'b010101, 6'b111111, 1'b0);
        checks++; if (snap_unknown !== ((kx + kz) > 0)) $display("FAIL known_unknown got %b want %b", snap_unknown, (kx + kz) > 0); else passes++;
        for (int i = 0; i < 13; i++) begin
            checks++; if (!out_valid || out_idx !== 4'(i)) $display("FAIL known_idx got v=%b idx=%0d want v=1 idx=%0d", out_valid, out_idx, i); else passes++;
            checks++; if (out_code !== exp_known[i]) $display("FAIL known_code idx%0d got %b want %b", i, out_code, exp_known[i]); else passes++;
            checks++; if (out_last !== (i == 12)) $display("FAIL known_last idx%0d got %b want %b", i, out_last, i == 12); else passes++;
            tick;
        end
        e8x += kx; e8z += kz;
        checks++; if (busy !== 1'b0) $display("FAIL known_busy_end got %b want 0", busy); else passes++;
        checks++; if (x_total !== 8'(e8x) || z_total !== 8'(e8z)) $display("FAIL known_totals got %0d/%0d want %0d/%0d", x_total, z_total, e8x, e8z); else passes++;
    endtask

    task automatic test_power_on;
        set_inputs(6'bx010xz, 6'bxxxxxx, 1'bx);
        out_ready = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        checks++; if (snap_unknown !== ((px + pz) > 0)) $display("FAIL pow_unknown got %b want %b", snap_unknown, (px + pz) > 0); else passes++;
        for (int i = 0; i < 13; i++) begin
            checks++; if (out_code !== exp_pow[i] || out_idx !== 4'(i)) $display("FAIL pow_code idx%0d got %b@%0d want %b", i, out_code, out_idx, exp_pow[i]); else passes++;
            tick;
        end
        e8x += px; e8z += pz;
        checks++; if (x_total !== 8'(e8x)) $display("FAIL pow_x_total got %0d want %0d", x_total, e8x); else passes++;
        checks++; if (z_total !== 8'(e8z)) $display("FAIL pow_z_total got %0d want %0d", z_total, e8z); else passes++;
    endtask

    task automatic test_backpressure;
        int beats;
        set_inputs(6'bx010xz, 6'bxxxxxx, 1'bx);
        out_ready = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        beats = 0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid && out_ready) beats++;
            if (exp_pow[i] == 2'b10) e8x++;
            if (exp_pow[i] == 2'b11) e8z++;
            tick;
        end
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick;
            if (out_valid && out_ready) beats++;
            checks++; if (out_valid !== 1'b1 || out_idx !== 4'd4) $display("FAIL stall_idx cyc%0d got v=%b idx=%0d want v=1 idx=4", s, out_valid, out_idx); else passes++;
            checks++; if (out_code !== exp_pow[4]) $display("FAIL stall_code cyc%0d got %b want %b", s, out_code, exp_pow[4]); else passes++;
            checks++; if (x_total !== 8'(e8x) || z_total !== 8'(e8z)) $display("FAIL stall_totals cyc%0d got %0d/%0d want %0d/%0d", s, x_total, z_total, e8x, e8z); else passes++;
        end
        out_ready = 1'b1;
        for (int i = 4; i < 13; i++) begin
            checks++; if (out_idx !== 4'(i) || out_code !== exp_pow[i]) $display("FAIL resume idx got %0d/%b want %0d/%b", out_idx, out_code, i, exp_pow[i]); else passes++;
            if (out_valid && out_ready) beats++;
            if (exp_pow[i] == 2'b10) e8x++;
            if (exp_pow[i] == 2'b11) e8z++;
            tick;
        end
        checks++; if (beats != 13) $display("FAIL bp_beats got %0d want 13", beats); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL bp_busy_end got %b want 0", busy); else passes++;
        checks++; if (x_total !== 8'(e8x) || z_total !== 8'(e8z)) $display("FAIL bp_totals got %0d/%0d want %0d/%0d", x_total, z_total, e8x, e8z); else passes++;
    endtask

    task automatic test_back_to_back;
        int k, pos, t;
        logic [1:0] want;
        set_inputs(6'b101010, 6'b000000, 1'b1);
        out_ready = 1'b1; start = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            tick;
            k = (n - 1) / 14;
            pos = (n - 1) % 14;
            if (pos == 13) begin
                checks++; if (busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL b2b_idle n%0d got busy=%b v=%b want 0/0", n, busy, out_valid); else passes++;
            end else begin
                want = (k == 1) ? exp_pow[pos] : exp_known[pos];
                checks++; if (busy !== 1'b1 || out_idx !== 4'(pos)) $display("FAIL b2b_idx n%0d got busy=%b idx=%0d want 1/%0d", n, busy, out_idx, pos); else passes++;
                checks++; if (out_code !== want) $display("FAIL b2b_code n%0d got %b want %b", n, out_code, want); else passes++;
            end
            if (n == 3)  set_inputs(6'bx010xz, 6'bxxxxxx, 1'bx);
            if (n == 20) set_inputs(6'b101010, 6'b000000, 1'b1);
        end
        start = 1'b0;
        t = 0;
        while (busy && t < 20) begin
            tick;
            t++;
        end
        checks++; if (busy !== 1'b0) $display("FAIL b2b_drain timeout busy got %b want 0", busy); else passes++;
        e8x += 2 * kx + px; e8z += 2 * kz + pz;
        checks++; if (x_total !== 8'(e8x) || z_total !== 8'(e8z)) $display("FAIL b2b_totals got %0d/%0d want %0d/%0d", x_total, z_total, e8x, e8z); else passes++;
    endtask

    task automatic test_rst_mid;
        set_inputs(6'bx010xz, 6'bxxxxxx, 1'bx);
        out_ready = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick;
        checks++; if (out_idx !== 4'd7) $display("FAIL rstmid_pre idx got %0d want 7", out_idx); else passes++;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL rstmid_ctl got v=%b busy=%b want 0/0", out_valid, busy); else passes++;
        checks++; if (x_total !== 8'd0 || z_total !== 8'd0) $display("FAIL rstmid_totals got %0d/%0d want 0/0", x_total, z_total); else passes++;
        checks++; if (snap_unknown !== 1'b0) $display("FAIL rstmid_unknown got %b want 0", snap_unknown); else passes++;
        tick; tick;
        checks++; if (out_valid !== 1'b0 || out_idx !== 4'd0) $display("FAIL rstmid_after got v=%b idx=%0d want 0/0", out_valid, out_idx); else passes++;
        e8x = 0; e8z = 0;
    endtask

    task automatic test_saturate;
        set_inputs(6'bx010xz, 6'bxxxxxx, 1'bx);
        out_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            start = 1'b1;
            tick;
            start = 1'b0;
            for (int i = 0; i < 13; i++) tick;
        end
        checks++; if (x4 !== 4'(sat4(2 * px))) $display("FAIL sat_x4 got %0d want %0d", x4, sat4(2 * px)); else passes++;
        checks++; if (z4 !== 4'(sat4(2 * pz))) $display("FAIL sat_z4 got %0d want %0d", z4, sat4(2 * pz)); else passes++;
        checks++; if (x_total !== 8'(2 * px)) $display("FAIL sat_x8 got %0d want %0d", x_total, 2 * px); else passes++;
        start = 1'b1;
        tick;
        start = 1'b0;
        clr_stats = 1'b1;
        tick;
        clr_stats = 1'b0;
        checks++; if (x4 !== 4'd0 || z4 !== 4'd0) $display("FAIL clr_wins4 got %0d/%0d want 0/0", x4, z4); else passes++;
        checks++; if (x_total !== 8'd0) $display("FAIL clr_wins8 got %0d want 0", x_total); else passes++;
        for (int i = 1; i < 13; i++) tick;
        checks++; if (x4 !== 4'(sat4(px_tail)) || z4 !== 4'(sat4(pz_tail))) $display("FAIL clr_tail4 got %0d/%0d want %0d/%0d", x4, z4, sat4(px_tail), sat4(pz_tail)); else passes++;
        checks++; if (busy4 !== 1'b0) $display("FAIL clr_busy4 got %b want 0", busy4); else passes++;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; clr_stats = 1'b0; out_ready = 1'b0;
        build_tables();
        test_reset();
        test_known();
        test_power_on();
        test_backpressure();
        test_back_to_back();
        test_rst_mid();
        test_saturate();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
